// File: rtl/multi_prescaler.sv
// Lock-gated multi-channel prescaler: each channel emits a tick every div cycles and a
// square wave of period 2*div; new divisors are double-buffered and swap in on a period boundary.
module multi_prescaler #(
    parameter int NCH      = 2,
    parameter int WIDTH    = 24,
    parameter int DIV_INIT = 12000000,
    parameter int SETTLE   = 16,
    localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clkin,
    input  logic             reset_n,
    input  logic             lock,
    input  logic [NCH-1:0]   en,
    input  logic             load,
    input  logic [CHW-1:0]   load_ch,
    input  logic [WIDTH-1:0] load_div,
    output logic             load_ack,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   sq,
    output logic             running
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        WAIT_LOCK   = 2'd0,
        SETTLE_WAIT = 2'd1,
        RUN         = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [SW-1:0]    settle_r;
    logic [SW-1:0]    settle_nxt_s;
    logic             running_r;
    logic             load_ack_r;
    logic             in_run_s;
    logic [NCH-1:0]   ch_apply_s;

    // A divisor of zero behaves like one so the channel still ticks every cycle.
    function automatic logic [WIDTH-1:0] eff_div(input logic [WIDTH-1:0] d);
        return (d == {WIDTH{1'b0}}) ? WIDTH'(1'b1) : d;
    endfunction

    assign in_run_s = (state_r == RUN) && lock;

    // Lock sequencing: wait for lock, count SETTLE stable cycles, then run.
    always_comb begin
        state_nxt_s  = state_r;
        settle_nxt_s = settle_r;
        if (!lock) begin
            state_nxt_s  = WAIT_LOCK;
            settle_nxt_s = {SW{1'b0}};
        end else begin
            case (state_r)
                WAIT_LOCK: begin
                    state_nxt_s  = SETTLE_WAIT;
                    settle_nxt_s = {SW{1'b0}};
                end
                SETTLE_WAIT: begin
                    if (settle_r == SW'(SETTLE - 1)) begin
                        state_nxt_s = RUN;
                    end else begin
                        settle_nxt_s = settle_r + SW'(1'b1);
                    end
                end
                RUN: begin
                    state_nxt_s = RUN;
                end
                default: begin
                    state_nxt_s  = WAIT_LOCK;
                    settle_nxt_s = {SW{1'b0}};
                end
            endcase
        end
    end

    // FSM state, settle counter and the shared status outputs.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= WAIT_LOCK;
            settle_r   <= {SW{1'b0}};
            running_r  <= 1'b0;
            load_ack_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            settle_r   <= settle_nxt_s;
            running_r  <= (state_nxt_s == RUN);
            load_ack_r <= |ch_apply_s;
        end
    end

    assign running  = running_r;
    assign load_ack = load_ack_r;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [WIDTH-1:0] div_r;
        logic [WIDTH-1:0] shadow_r;
        logic [WIDTH-1:0] cnt_r;
        logic             pend_r;
        logic             tick_r;
        logic             sq_r;
        logic [WIDTH-1:0] div_nxt_s;
        logic [WIDTH-1:0] shadow_nxt_s;
        logic [WIDTH-1:0] cnt_nxt_s;
        logic [WIDTH-1:0] eff_cur_s;
        logic [WIDTH-1:0] eff_nxt_s;
        logic             pend_nxt_s;
        logic             tick_nxt_s;
        logic             sq_nxt_s;
        logic             counting_s;
        logic             wrap_s;
        logic             apply_s;
        logic             hit_s;

        assign hit_s = load && (load_ch == CHW'(gi));

        // Counter/divisor update; the swap uses the old pend so a load on the wrap edge waits a period.
        always_comb begin
            eff_cur_s  = eff_div(div_r);
            counting_s = in_run_s && en[gi];
            wrap_s     = counting_s && (cnt_r >= (eff_cur_s - WIDTH'(1'b1)));
            apply_s    = pend_r && (wrap_s || !counting_s);
            div_nxt_s  = apply_s ? shadow_r : div_r;
            eff_nxt_s  = eff_div(div_nxt_s);
            cnt_nxt_s  = cnt_r;
            tick_nxt_s = 1'b0;
            sq_nxt_s   = sq_r;
            if (!lock) begin
                cnt_nxt_s = {WIDTH{1'b0}};
                sq_nxt_s  = 1'b0;
            end else if (counting_s) begin
                if (wrap_s) begin
                    cnt_nxt_s = {WIDTH{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r + WIDTH'(1'b1);
                end
                tick_nxt_s = (cnt_nxt_s == (eff_nxt_s - WIDTH'(1'b1)));
                sq_nxt_s   = sq_r ^ tick_nxt_s;
            end else if (apply_s && (cnt_r >= eff_nxt_s)) begin
                cnt_nxt_s = {WIDTH{1'b0}};
            end else begin
                cnt_nxt_s = cnt_r;
            end
            if (hit_s) begin
                shadow_nxt_s = load_div;
                pend_nxt_s   = 1'b1;
            end else begin
                shadow_nxt_s = shadow_r;
                pend_nxt_s   = pend_r && !apply_s;
            end
        end

        // Per-channel state registers.
        always_ff @(posedge clkin or negedge reset_n) begin
            if (!reset_n) begin
                div_r    <= WIDTH'(DIV_INIT);
                shadow_r <= {WIDTH{1'b0}};
                cnt_r    <= {WIDTH{1'b0}};
                pend_r   <= 1'b0;
                tick_r   <= 1'b0;
                sq_r     <= 1'b0;
            end else begin
                div_r    <= div_nxt_s;
                shadow_r <= shadow_nxt_s;
                cnt_r    <= cnt_nxt_s;
                pend_r   <= pend_nxt_s;
                tick_r   <= tick_nxt_s;
                sq_r     <= sq_nxt_s;
            end
        end

        assign tick[gi]       = tick_r;
        assign sq[gi]         = sq_r;
        assign ch_apply_s[gi] = apply_s;
    end

endmodule

// File: tb/tb_multi_prescaler.sv
// Scoreboard bench for multi_prescaler: a cycle-level reference model predicts each cycle's
// outputs into a queue, and a negedge monitor pops and compares them against the DUT.
module tb_multi_prescaler;
    localparam int NCH = 2, WIDTH = 8, DIV_INIT = 4, SETTLE = 3;

    logic       clk = 1'b0;
    logic       reset_n, lock, load, load_ch;
    logic [1:0] en;
    logic [7:0] load_div;
    logic       load_ack, running;
    logic [1:0] tick, sq;

    logic [2:0] en3;
    logic       load3, ack3, run3;
    logic [1:0] load_ch3;
    logic [7:0] load_div3;
    logic [2:0] tick3, sq3;

    multi_prescaler #(.NCH(NCH), .WIDTH(WIDTH), .DIV_INIT(DIV_INIT), .SETTLE(SETTLE)) dut (
        .clkin(clk), .reset_n(reset_n), .lock(lock), .en(en), .load(load),
        .load_ch(load_ch), .load_div(load_div), .load_ack(load_ack),
        .tick(tick), .sq(sq), .running(running));

    // Three-channel copy so that load_ch=3 is a representable out-of-range value.
    multi_prescaler #(.NCH(3), .WIDTH(WIDTH), .DIV_INIT(DIV_INIT), .SETTLE(SETTLE)) dut3 (
        .clkin(clk), .reset_n(reset_n), .lock(lock), .en(en3), .load(load3),
        .load_ch(load_ch3), .load_div(load_div3), .load_ack(ack3),
        .tick(tick3), .sq(sq3), .running(run3));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] tick;
        logic [1:0] sq;
        logic       run;
        logic       ack;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0, n_bad = 0;
    int run_rise = -1;
    int t0_log[$];
    int ack_log[$];
    bit chk3 = 1'b0;
    int last3[3] = '{-1, -1, -1};
    int n3[3] = '{0, 0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    // Reference model: running after SETTLE+1 consecutive lock-high edges; each channel
    // counts phase modulo its effective divisor, swapping in a pending divisor at period end.
    int m_streak;
    int m_div[2], m_sh[2], m_ph[2];
    bit m_pend[2], m_tick[2], m_sq[2];
    bit m_ack;

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic model_step(input logic r, input logic lk, input logic [1:0] e,
                              input logic ld, input logic c, input logic [7:0] d);
        bit run_before, on, p_end, app, any;
        if (!r) begin
            m_streak = 0;
            m_ack = 0;
            for (int i = 0; i < 2; i++) begin
                m_div[i] = DIV_INIT; m_sh[i] = 0; m_ph[i] = 0;
                m_pend[i] = 0; m_tick[i] = 0; m_sq[i] = 0;
            end
            return;
        end
        run_before = (m_streak >= SETTLE + 1);
        any = 0;
        for (int i = 0; i < 2; i++) begin
            on    = run_before && lk && e[i];
            p_end = on && (m_ph[i] + 1 >= eff(m_div[i]));
            app   = m_pend[i] && (p_end || !on);
            if (app) begin
                m_div[i] = m_sh[i];
                m_pend[i] = 0;
                any = 1;
            end
            if (!lk) begin
                m_ph[i] = 0; m_tick[i] = 0; m_sq[i] = 0;
            end else if (on) begin
                m_ph[i] = p_end ? 0 : m_ph[i] + 1;
                m_tick[i] = (m_ph[i] == eff(m_div[i]) - 1);
                m_sq[i] = m_sq[i] ^ m_tick[i];
            end else begin
                m_tick[i] = 0;
                if (app && m_ph[i] >= eff(m_div[i])) m_ph[i] = 0;
            end
            if (ld && int'(c) == i) begin
                m_sh[i] = int'(d);
                m_pend[i] = 1;
            end
        end
        m_ack = any;
        m_streak = lk ? m_streak + 1 : 0;
    endtask

    task automatic drive(input logic r, input logic lk, input logic [1:0] e, input logic ld,
                         input logic c, input logic [7:0] d, input logic ld3);
        exp_t x;
        // Async reset forces the current cycle's outputs low immediately.
        if (!r && reset_n && sb.size() > 0 && sb[sb.size() - 1].cyc == cyc) begin
            x = sb[sb.size() - 1];
            x.tick = 2'b00; x.sq = 2'b00; x.run = 1'b0; x.ack = 1'b0;
            sb[sb.size() - 1] = x;
        end
        reset_n = r; lock = lk; en = e; load = ld; load_ch = c; load_div = d;
        load3 = ld3; load_ch3 = 2'd3; load_div3 = 8'd1;
        model_step(r, lk, e, ld, c, d);
        x.cyc  = cyc + 1;
        x.tick = {m_tick[1], m_tick[0]};
        x.sq   = {m_sq[1], m_sq[0]};
        x.run  = (m_streak >= SETTLE + 1);
        x.ack  = m_ack;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every presented cycle against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb[0];
            if (e.cyc < cyc) begin
                void'(sb.pop_front());
                chk("sb_late", 32'(e.cyc), 32'(cyc));
            end else if (e.cyc == cyc) begin
                void'(sb.pop_front());
                chk("tick", 32'(tick), 32'(e.tick));
                chk("sq", 32'(sq), 32'(e.sq));
                chk("running", 32'(running), 32'(e.run));
                chk("load_ack", 32'(load_ack), 32'(e.ack));
                chk("running3", 32'(run3), 32'(e.run));
            end
        end
        chk("load_ack3", 32'(ack3), 32'd0);
        if (running && run_rise < 0) run_rise = cyc;
        if (tick[0] && cyc <= 26) t0_log.push_back(cyc);
        if (load_ack && cyc <= 35) ack_log.push_back(cyc);
        if (chk3) begin
            for (int c = 0; c < 3; c++) begin
                if (tick3[c]) begin
                    if (last3[c] >= 0) chk("dut3_spacing", 32'(cyc - last3[c]), 32'd4);
                    last3[c] = cyc;
                    n3[c]++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] re;
        int rst_hold;
        reset_n = 1'b1; lock = 1'b0; en = 2'b00; load = 1'b0; load_ch = 1'b0; load_div = 8'd0;
        en3 = 3'b111; load3 = 1'b0; load_ch3 = 2'd3; load_div3 = 8'd1;
        #1 reset_n = 1'b0;
        #1;
        chk("reset_tick", 32'(tick), 32'd0);
        chk("reset_sq", 32'(sq), 32'd0);
        chk("reset_running", 32'(running), 32'd0);
        chk("reset_ack", 32'(load_ack), 32'd0);

        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'd0, 1'b0);
        for (int k = 0; k < 7; k++) drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'd0, 1'b0);
        for (int k = 0; k < 17; k++) drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 8'd0, 1'b0);
        chk("run_rise_cycle", 32'(run_rise), 32'd14);
        chk("tick0_count", 32'(t0_log.size()), 32'd3);
        if (t0_log.size() == 3) begin
            chk("tick0_first", 32'(t0_log[0]), 32'd17);
            chk("tick0_second", 32'(t0_log[1]), 32'd21);
            chk("tick0_third", 32'(t0_log[2]), 32'd25);
        end

        // Mid-period reload of ch0 to 2.
        drive(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 8'd2, 1'b0);
        for (int k = 0; k < 8; k++) drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 8'd0, 1'b0);
        chk("ack_count", 32'(ack_log.size()), 32'd1);
        if (ack_log.size() == 1) chk("ack_cycle", 32'(ack_log[0]), 32'd30);

        // ch1 to divisor 0, and out-of-range load on the 3-channel copy.
        chk3 = 1'b1;
        drive(1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 8'd0, 1'b1);
        for (int k = 0; k < 20; k++) drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 8'd0, 1'b0);
        chk3 = 1'b0;
        for (int c = 0; c < 3; c++) chk("dut3_tick_count", 32'(n3[c]), 32'd5);

        // Longer divisor, then freeze ch0 for 5 cycles and resume.
        drive(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 8'd6, 1'b0);
        for (int k = 0; k < 10; k++) drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 8'd0, 1'b0);
        for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 8'd0, 1'b0);
        for (int k = 0; k < 8; k++) drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 8'd0, 1'b0);
        // Shrink the divisor while frozen so the count is clipped back to zero.
        drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 8'd0, 1'b0);
        drive(1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 8'd2, 1'b0);
        for (int k = 0; k < 2; k++) drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 8'd0, 1'b0);
        for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 8'd0, 1'b0);

        // One-cycle lock drop.
        drive(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 8'd0, 1'b0);
        for (int k = 0; k < 20; k++) drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 8'd0, 1'b0);

        // Reset with a load still pending.
        drive(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 8'd5, 1'b0);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'd0, 1'b0);
        for (int k = 0; k < 20; k++) drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 8'd0, 1'b0);

        // Randomized traffic.
        re = 2'b11;
        rst_hold = 0;
        for (int k = 0; k < 300; k++) begin
            logic r, lk, ld, c, ld3;
            logic [7:0] d;
            r = 1'b1;
            if (rst_hold > 0) begin
                r = 1'b0;
                rst_hold--;
            end else if ($urandom_range(199) == 0) begin
                r = 1'b0;
                rst_hold = int'($urandom_range(2));
            end
            lk = ($urandom_range(49) != 0);
            if ($urandom_range(7) == 0) re = 2'($urandom_range(3));
            ld  = ($urandom_range(5) == 0);
            c   = 1'($urandom_range(1));
            d   = 8'($urandom_range(7));
            ld3 = ($urandom_range(9) == 0);
            drive(r, lk, re, ld, c, d, ld3);
        end

        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multi_prescaler.md
MULTI_PRESCALER -- requirements
Module: multi_prescaler

Interface
REQ-001 The module SHALL have parameter NCH, default 2, meaning number of independent prescaler channels (1..8).
REQ-002 The module SHALL have parameter WIDTH, default 24, meaning divisor and counter width in bits.
REQ-003 The module SHALL have parameter DIV_INIT, default 12000000, meaning reset divisor of every channel.
REQ-004 The module SHALL have parameter SETTLE, default 16, meaning clkin cycles lock must stay high before counting starts (>=1).
REQ-005 The module SHALL have port clkin, input, 1 bit, meaning the single clock, typically the PLL clkout; all logic on its rising edge.
REQ-006 The module SHALL have port reset_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-007 The module SHALL have port lock, input, 1 bit, meaning PLL lock indicator, synchronous to clkin.
REQ-008 The module SHALL have port en, input, NCH bits, meaning per-channel count enable.
REQ-009 The module SHALL have port load, input, 1 bit, meaning single-cycle divisor load strobe.
REQ-010 The module SHALL have port load_ch, input, CHW bits, meaning target channel, where CHW = max(1, clog2(NCH)).
REQ-011 The module SHALL have port load_div, input, WIDTH bits, meaning new divisor.
REQ-012 The module SHALL have port load_ack, output, 1 bit, meaning one-cycle pulse when a loaded divisor becomes active.
REQ-013 The module SHALL have port tick, output, NCH bits, meaning per-channel one-cycle pulse every div cycles.
REQ-014 The module SHALL have port sq, output, NCH bits, meaning per-channel square wave toggling on each tick (period 2*div).
REQ-015 The module SHALL have port running, output, 1 bit, meaning high in RUN state.

Function
REQ-016 The control FSM SHALL have states WAIT_LOCK, SETTLE_WAIT and RUN.
REQ-017 The FSM SHALL transition WAIT_LOCK->SETTLE_WAIT when lock=1, clearing the settle counter.
REQ-018 The FSM SHALL transition SETTLE_WAIT->RUN after lock has been high for SETTLE consecutive cycles, so running rises SETTLE+1 cycles after lock rises.
REQ-019 The FSM SHALL return to WAIT_LOCK in the next cycle from any state when lock=0, and in that cycle SHALL clear all cnt, tick and sq to 0; div and shadow registers SHALL be retained.
REQ-020 Each channel SHALL hold div, shadow, pend and cnt registers, each WIDTH bits except pend (1 bit).
REQ-021 In RUN with en[i]=1, cnt[i] SHALL increment each cycle; when cnt[i] = eff_div-1, cnt[i] SHALL wrap to 0, tick[i] SHALL be 1 in that cycle (registered), and sq[i] SHALL toggle.
REQ-022 eff_div SHALL equal div, except that div=0 SHALL be treated as 1, so that div 0 or 1 gives tick high every cycle.
REQ-023 When en[i]=0, channel i SHALL freeze cnt and sq and drive tick[i]=0; counting SHALL resume from the frozen cnt.
REQ-024 A load with load_ch<NCH SHALL write load_div to shadow[load_ch] and set pend; a later load to the same channel before application SHALL overwrite shadow.
REQ-025 A load with load_ch>=NCH SHALL be ignored, with no ack.
REQ-026 A pending shadow SHALL be copied to div at that channel's next wrap cycle, taking effect for the following period, or on the next cycle if the channel is not counting (en=0 or not RUN).
REQ-027 When a pending shadow is applied, the block SHALL clear pend and pulse load_ack for 1 cycle in the cycle after application.
REQ-028 If cnt[i] >= new eff_div at application while not counting, cnt[i] SHALL be cleared to 0.
REQ-029 If several channels apply in the same cycle, load_ack SHALL pulse once.
REQ-030 A load arriving in the same cycle as a wrap of that channel SHALL be applied at the next wrap, not the current one.

Reset
REQ-031 While reset_n=0, the block SHALL be in state WAIT_LOCK with cnt=0, shadow=0, pend=0, tick=0, sq=0, load_ack=0, running=0, div=DIV_INIT.
REQ-032 Reset deassertion SHALL take effect at the first clkin edge after reset_n rises, and the block SHALL still require lock plus SETTLE cycles before counting.
REQ-033 Reset asserted mid-period SHALL discard pending loads.

Verification
Benches use NCH=2, WIDTH=8, DIV_INIT=4, SETTLE=3.
REQ-034 The bench SHALL drive lock high at cycle 10 with en=2'b11 and check: running high at cycle 14; tick[0] at cycles 17, 21, 25; sq[0] toggles at each tick.
REQ-035 The bench SHALL load ch0 with div 2 mid-period and check: the current 4-cycle period completes, then ticks every 2 cycles, and load_ack occurs 1 cycle after the wrap.
REQ-036 The bench SHALL load ch1 with div 0 and, separately, with load_ch=3, and check: ch1 ticks every cycle; the out-of-range load causes no ack and no change.
REQ-037 The bench SHALL drop lock for 1 cycle during RUN and check: tick, sq and cnt clear; running low; the block restarts after 3+1 cycles; div is kept.
REQ-038 The bench SHALL hold en[0]=0 for 5 cycles mid-count and check: tick[0] is 0 and sq[0] is held, and the remaining count resumes from the frozen value.
REQ-039 The bench SHALL assert reset_n=0 with a pending load and check: all outputs 0, div back to 4, and no load_ack after release.
